// File: rtl/barrett_stream_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : barrett_stream_reducer
//  Description : Fully pipelined Barrett modular reducer, r = x mod m for
//                x < 2^(2*WIDTH). It uses a runtime-loadable (m, mu) pair with
//                mu = floor(2^(2*WIDTH) / m). Valid/ready streaming is used on
//                both sides, and an in-order ID tag travels with each operand.
//
//  Ports       : clk_i, rst_i                 clock, sync active-high reset
//                cfg_valid_i/cfg_ready_o      modulus load handshake
//                cfg_m_i, cfg_mu_i            modulus and Barrett constant
//                cfg_loaded_o                 a modulus is present
//                in_valid_i/in_ready_o        operand handshake
//                in_x_i, in_id_i              operand and tag
//                out_valid_o/out_ready_i      result handshake
//                out_r_o, out_id_o            residue and tag
//                busy_o                       any stage holds a valid entry
//
//  Pipeline    : S1 register x | S2 q = hi(x*mu) | S3 t = x - q*m |
//                S4 r = t >= m ? t - m : t
//  Revision    : 1.0  initial release
// ============================================================================
module barrett_stream_reducer #(
    parameter int WIDTH = 32,
    parameter int ID_W  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [WIDTH-1:0]     cfg_m_i,
    input  logic [2*WIDTH-1:0]   cfg_mu_i,
    output logic                 cfg_loaded_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2*WIDTH-1:0]   in_x_i,
    input  logic [ID_W-1:0]      in_id_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     out_r_o,
    output logic [ID_W-1:0]      out_id_o,
    output logic                 busy_o
);

    localparam int c_XW = 2 * WIDTH;
    localparam int c_PW = 4 * WIDTH;

    // Configuration registers
    logic [WIDTH-1:0]   r_m;
    logic [c_XW-1:0]    r_mu;
    logic               r_loaded;

    // Pipeline stage registers
    logic               r_s1_v;
    logic [c_XW-1:0]    r_s1_x;
    logic [ID_W-1:0]    r_s1_id;

    logic               r_s2_v;
    logic [WIDTH:0]     r_s2_x_lo;
    logic [WIDTH:0]     r_s2_q_lo;
    logic [ID_W-1:0]    r_s2_id;

    logic               r_s3_v;
    logic [WIDTH:0]     r_s3_t;
    logic [ID_W-1:0]    r_s3_id;

    logic               r_s4_v;
    logic [WIDTH-1:0]   r_s4_r;
    logic [ID_W-1:0]    r_s4_id;

    logic               w_adv;
    logic               w_busy;
    logic               w_in_fire;
    logic               w_cfg_fire;
    logic [WIDTH:0]     w_q_lo;
    logic [WIDTH:0]     w_qm_lo;
    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_t_sub;
    logic [WIDTH-1:0]   w_r;

    // Global stall: the whole pipe advances unless S4 holds an unaccepted result.
    assign w_adv      = ~(r_s4_v & ~out_ready_i);
    assign w_busy     = r_s1_v | r_s2_v | r_s3_v | r_s4_v;

    assign cfg_ready_o  = ~w_busy;
    assign cfg_loaded_o = r_loaded;
    // Config requests win over operands, so a load and an accept never coincide.
    assign in_ready_o   = r_loaded & ~cfg_valid_i & w_adv;
    assign busy_o       = w_busy;

    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_cfg_fire = cfg_valid_i & cfg_ready_o;

    // Full 4K-bit product, then shift by 2K. True t lies in [0, 2m) < 2^(K+1),
    // so x - q*m is exact modulo 2^(K+1). Only the low K+1 bits of q and x
    // need to travel past S2.
    assign w_q_lo  = (WIDTH+1)'(({{c_XW{1'b0}}, r_s1_x} * {{c_XW{1'b0}}, r_mu}) >> c_XW);
    assign w_m_ext = {1'b0, r_m};
    assign w_qm_lo = r_s2_q_lo * w_m_ext;
    assign w_t     = r_s2_x_lo - w_qm_lo;
    assign w_t_sub = r_s3_t - w_m_ext;
    assign w_r     = (r_s3_t >= w_m_ext) ? WIDTH'(w_t_sub) : WIDTH'(r_s3_t);

    // Modulus / mu registers. A load is only possible with an empty pipe, so
    // in-flight results are never affected by it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m      <= '0;
            r_mu     <= '0;
            r_loaded <= 1'b0;
        end else if (w_cfg_fire) begin
            r_m      <= cfg_m_i;
            r_mu     <= cfg_mu_i;
            r_loaded <= 1'b1;
        end
    end

    // Pipeline. Bubbles shift along with valid entries whenever w_adv is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_v    <= 1'b0;
            r_s1_x    <= '0;
            r_s1_id   <= '0;
            r_s2_v    <= 1'b0;
            r_s2_x_lo <= '0;
            r_s2_q_lo <= '0;
            r_s2_id   <= '0;
            r_s3_v    <= 1'b0;
            r_s3_t    <= '0;
            r_s3_id   <= '0;
            r_s4_v    <= 1'b0;
            r_s4_r    <= '0;
            r_s4_id   <= '0;
        end else if (w_adv) begin
            r_s1_v    <= w_in_fire;
            r_s1_x    <= in_x_i;
            r_s1_id   <= in_id_i;

            r_s2_v    <= r_s1_v;
            r_s2_x_lo <= r_s1_x[WIDTH:0];
            r_s2_q_lo <= w_q_lo;
            r_s2_id   <= r_s1_id;

            r_s3_v    <= r_s2_v;
            r_s3_t    <= w_t;
            r_s3_id   <= r_s2_id;

            r_s4_v    <= r_s3_v;
            r_s4_r    <= w_r;
            r_s4_id   <= r_s3_id;
        end
    end

    assign out_valid_o = r_s4_v;
    assign out_r_o     = r_s4_r;
    assign out_id_o    = r_s4_id;

endmodule
`default_nettype wire

// File: tb/tb_barrett_stream_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrett_stream_reducer
//  Description : Directed self-checking bench for barrett_stream_reducer
//                (WIDTH=32, ID_W=4). A negedge monitor records every
//                completed output handshake. The main sequence checks the
//                recorded results against hand-computed residues.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_barrett_stream_reducer;

    localparam int W  = 32;
    localparam int IW = 4;
    localparam logic [63:0] c_MU13 = 64'd1418980313362273201;
    localparam logic [31:0] c_M1   = 32'h92153525;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_valid_i;
    logic            cfg_ready_o;
    logic [W-1:0]    cfg_m_i;
    logic [2*W-1:0]  cfg_mu_i;
    logic            cfg_loaded_o;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2*W-1:0]  in_x_i;
    logic [IW-1:0]   in_id_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [W-1:0]    out_r_o;
    logic [IW-1:0]   out_id_o;
    logic            busy_o;

    barrett_stream_reducer #(.WIDTH(W), .ID_W(IW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_m_i      (cfg_m_i),
        .cfg_mu_i     (cfg_mu_i),
        .cfg_loaded_o (cfg_loaded_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_x_i       (in_x_i),
        .in_id_i      (in_id_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_r_o      (out_r_o),
        .out_id_o     (out_id_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  r;
        logic [IW-1:0] id;
        int            c;
    } rec_t;
    rec_t q[$];

    always @(negedge clk) begin
        if (out_valid_o === 1'b1 && out_ready_i === 1'b1)
            q.push_back('{out_r_o, out_id_o, cyc});
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int i, input logic [W-1:0] er,
                           input logic [IW-1:0] eid);
        if (i < q.size()) begin
            chk({tag, "_r"},  64'(q[i].r),  64'(er));
            chk({tag, "_id"}, 64'(q[i].id), 64'(eid));
        end else begin
            n_total++;
            n_fail++;
            $error("FAIL %s result %0d observed=none expected=%0h", tag, i, er);
        end
    endtask

    // Waits (bounded) for n results, then a few more cycles to catch extras.
    task automatic drain(input string tag, input int n);
        for (int i = 0; i < 40 && q.size() < n; i++) step();
        for (int i = 0; i < 3; i++) step();
        chk({tag, "_count"}, 64'(q.size()), 64'(n));
    endtask

    task automatic send(input logic [63:0] x, input logic [IW-1:0] id, input string tag);
        in_valid_i = 1'b1;
        in_x_i     = x;
        in_id_i    = id;
        #1;
        chk1({tag, "_in_ready"}, in_ready_o, 1'b1);
        step();
        in_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [63:0]  xs [5];
    logic [31:0]  rs [5];
    logic [127:0] wide;
    logic [63:0]  mu1;
    int           t0;
    int           idx;
    int           waited;
    logic         ir;

    initial begin
        rst         = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_m_i     = '0;
        cfg_mu_i    = '0;
        in_valid_i  = 1'b0;
        in_x_i      = '0;
        in_id_i     = '0;
        out_ready_i = 1'b1;
        wide        = (128'd1 << 64) / {96'd0, c_M1};
        mu1         = wide[63:0];

        // ---------------- reset state ----------------
        step();
        step();
        rst = 1'b0;
        #1;
        chk1("rst_out_valid", out_valid_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_cfg_ready", cfg_ready_o, 1'b1);
        chk1("rst_in_ready", in_ready_o, 1'b0);
        chk1("rst_loaded", cfg_loaded_o, 1'b0);
        chk("rst_out_r", 64'(out_r_o), 64'd0);
        chk("rst_out_id", 64'(out_id_o), 64'd0);

        // ---------------- not configured ----------------
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("nocfg_in_ready", in_ready_o, 1'b0);
            chk1("nocfg_out_valid", out_valid_o, 1'b0);
            step();
        end
        cfg_valid_i = 1'b1;
        cfg_m_i     = 32'd13;
        cfg_mu_i    = c_MU13;
        #1;
        chk1("load_in_ready", in_ready_o, 1'b0);
        chk1("load_cfg_ready", cfg_ready_o, 1'b1);
        step();
        cfg_valid_i = 1'b0;
        chk1("load_loaded", cfg_loaded_o, 1'b1);

        // ---------------- basic reduction ----------------
        xs[0] = 64'd0;  xs[1] = 64'd12; xs[2] = 64'd13; xs[3] = 64'd100;
        xs[4] = 64'hFFFF_FFFF_FFFF_FFFF;
        rs[0] = 32'd0;  rs[1] = 32'd12; rs[2] = 32'd0;  rs[3] = 32'd9;  rs[4] = 32'd2;
        q.delete();
        t0 = cyc;
        for (int i = 0; i < 5; i++) send(xs[i], IW'(i), "basic");
        drain("basic", 5);
        for (int i = 0; i < 5; i++) begin
            chk_res("basic", i, rs[i], IW'(i));
            if (i < q.size()) chk("basic_latency", 64'(q[i].c), 64'(t0 + 4 + i));
        end

        // ---------------- backpressure ----------------
        q.delete();
        idx = 0;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            out_ready_i = !(k >= 3 && k <= 8);
            in_valid_i  = 1'b1;
            in_x_i      = 64'(14 + idx);
            in_id_i     = IW'(5 + idx);
            #1;
            ir = in_ready_o;
            if (k >= 4 && k <= 8) begin
                chk1("bp_in_ready", in_ready_o, 1'b0);
                chk1("bp_out_valid", out_valid_o, 1'b1);
                chk("bp_out_r_hold", 64'(out_r_o), 64'd1);
                chk("bp_out_id_hold", 64'(out_id_o), 64'd5);
            end
            step();
            if (ir) idx++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("bp_accepted", 64'(idx), 64'd6);
        drain("bp", 6);
        for (int i = 0; i < 6; i++) chk_res("bp", i, W'(1 + i), IW'(5 + i));

        // ---------------- reconfiguration ----------------
        q.delete();
        send(64'd26, 4'd1, "rcfg");
        send(64'd27, 4'd2, "rcfg");
        send(64'd40, 4'd3, "rcfg");
        cfg_valid_i = 1'b1;
        cfg_m_i     = c_M1;
        cfg_mu_i    = mu1;
        #1;
        chk1("rcfg_in_ready", in_ready_o, 1'b0);
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            if (cfg_ready_o === 1'b1) break;
            waited++;
            step();
        end
        chk("rcfg_wait", 64'(waited), 64'd4);
        step();
        cfg_valid_i = 1'b0;
        chk("rcfg_old_count", 64'(q.size()), 64'd3);
        chk_res("rcfg_old", 0, 32'd0, 4'd1);
        chk_res("rcfg_old", 1, 32'd1, 4'd2);
        chk_res("rcfg_old", 2, 32'd1, 4'd3);
        q.delete();
        send({32'd0, c_M1} * 64'd3 + 64'd7, 4'd7, "rcfg_new");
        drain("rcfg_new", 1);
        chk_res("rcfg_new", 0, 32'd7, 4'd7);

        // ---------------- simultaneous request ----------------
        q.delete();
        cfg_valid_i = 1'b1;
        cfg_m_i     = 32'd13;
        cfg_mu_i    = c_MU13;
        in_valid_i  = 1'b1;
        in_x_i      = 64'd100;
        in_id_i     = 4'd9;
        #1;
        chk1("sim_in_ready", in_ready_o, 1'b0);
        chk1("sim_cfg_ready", cfg_ready_o, 1'b1);
        step();
        cfg_valid_i = 1'b0;
        send(64'd100, 4'd9, "sim");
        drain("sim", 1);
        chk_res("sim", 0, 32'd9, 4'd9);

        // ---------------- reset mid-operation ----------------
        q.delete();
        send(64'd50, 4'd2, "mrst");
        send(64'd51, 4'd3, "mrst");
        send(64'd52, 4'd4, "mrst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk1("mrst_out_valid", out_valid_o, 1'b0);
        chk1("mrst_busy", busy_o, 1'b0);
        chk1("mrst_loaded", cfg_loaded_o, 1'b0);
        chk1("mrst_in_ready", in_ready_o, 1'b0);
        chk1("mrst_cfg_ready", cfg_ready_o, 1'b1);
        chk("mrst_out_r", 64'(out_r_o), 64'd0);
        for (int i = 0; i < 10; i++) step();
        chk("mrst_no_stale", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/barrett_stream_reducer.md
# barrett_stream_reducer

Parametrised, fully pipelined Barrett modular reducer with valid/ready streaming on both sides, a runtime-loadable modulus/μ pair and in-order ID tagging. It computes r = x mod m for any x < 2^(2·WIDTH) using the full-precision quotient estimate q = ⌊x·μ / 2^(2·WIDTH)⌋. The bound on x makes one conditional subtraction sufficient. The block sits between operand producers, such as the multiplier pipeline, and downstream modular-arithmetic consumers.

## Interface
- WIDTH, 32: modulus width K in bits. Result width is K, operand width is 2K.
- ID_W, 4: width of the transaction tag carried alongside each operand.
- clk_i  in  1  clock. Everything is sampled on the rising edge.
- rst_i  in  1  reset. Synchronous and active-high (already decided).
- cfg_valid_i  in  1  modulus load request.
- cfg_ready_o  out  1  the block can accept a modulus load.
- cfg_m_i  in  WIDTH  modulus m, with 2 ≤ m < 2^K.
- cfg_mu_i  in  2·WIDTH  μ = ⌊2^(2K) / m⌋, precomputed by the producer.
- cfg_loaded_o  out  1  a modulus has been loaded since reset.
- in_valid_i  in  1  operand valid.
- in_ready_o  out  1  operand accepted this cycle when in_valid_i is also high.
- in_x_i  in  2·WIDTH  operand x.
- in_id_i  in  ID_W  tag for the operand.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_r_o  out  WIDTH  x mod m.
- out_id_o  out  ID_W  tag of the result.
- busy_o  out  1  at least one pipeline stage holds a valid entry.

## Operation
- Four register stages: S1, S2, S3, S4. Each stage has its own valid bit. S4 drives the out_* ports.
  - S1: register x and id.
  - S2: P = x·μ (4K bits). Keep q = P[4K-1:2K]. Carry x forward.
  - S3: t = x − q·m, computed in K+1 bits. Guaranteed 0 ≤ t < 2m.
  - S4: r = (t ≥ m) ? t − m : t. Truncate r to K bits.
- Global stall:
  - adv = ¬(S4.valid ∧ ¬out_ready_i).
  - When adv is high, all stages shift, and bubbles shift too.
  - When adv is low, all stage registers hold.
- Input acceptance:
  - in_ready_o = cfg_loaded_o ∧ ¬cfg_valid_i ∧ adv.
  - This is combinational from cfg_valid_i and out_ready_i.
  - A handshake loads S1 with valid=1. If adv is high without a handshake, S1.valid becomes 0.
- Modulus load:
  - cfg_ready_o = ¬busy_o.
  - On cfg_valid_i ∧ cfg_ready_o, m and μ are registered and cfg_loaded_o is set.
  - A load never alters an in-flight result.
  - A simultaneous configuration request takes priority over input; in_ready_o is forced low.
- Ordering: results leave strictly in acceptance order. out_id_o always matches the id accepted with that operand.
- Output stability: while out_valid_o ∧ ¬out_ready_i, out_r_o and out_id_o are held stable.
- Out-of-contract inputs: m < 2 or an inconsistent μ give an undefined result value. The handshake behaviour must still be correct.

## Timing
- Reset (rst_i high at an edge) clears the following registers to 0:
  - every stage valid bit, so out_valid_o = 0 and busy_o = 0;
  - out_r_o and out_id_o;
  - the m and μ registers;
  - cfg_loaded_o.
- Port values after reset:
  - cfg_ready_o = 1.
  - in_ready_o = 0 until the first modulus load.
- Reset mid-operation discards all in-flight entries. No result is emitted for them.
- Latency: an operand accepted in cycle t gives out_valid_o in cycle t+4 when there is no stall. Each stall cycle adds one.
- Throughput: one result per cycle while out_ready_i is held high.
- Capacity: at most 4 entries in flight. With S4 stalled, in_ready_o = 0, and nothing is lost or overwritten.
- Reconfiguration:
  - cfg_ready_o rises in the first cycle after the last entry leaves S4.
  - A load and an input handshake never complete in the same cycle.
- Boundary values:
  - x = 0 gives r = 0.
  - x = m − 1 gives r = m − 1.
  - x = 2^(2K) − 1 must be exact. The S2 product uses the full 4K bits with no truncation before the shift.

## Test plan
All scenarios use WIDTH=32, m=13 and μ=1418980313362273201 unless stated otherwise.

- **Basic reduction:** send x = 0, 12, 13, 100, then 2^64−1 back to back with ids 0..4 and out_ready_i=1.
  - Required results: r = 0, 12, 0, 9, 2.
  - Ids 0..4 appear on consecutive cycles, the first appearing 4 cycles after acceptance.
- **Not configured:** after reset, hold in_valid_i=1 for 5 cycles before any load.
  - in_ready_o stays 0 and out_valid_o stays 0.
  - After the load, the first operand is accepted in the next cycle.
- **Backpressure:** stream 6 operands (x = 14..19) with out_ready_i=0 for cycles 3–8.
  - in_ready_o drops once 4 entries are in flight.
  - out_r_o holds at 1 while stalled.
  - Final outputs are 1,2,3,4,5,6 in order, with correct ids and no duplicates.
- **Reconfiguration:** with 3 entries in flight, assert cfg_valid_i with m=0x92153525 and μ=⌊2^64/m⌋ (computed by the bench).
  - cfg_ready_o stays 0 until the pipeline drains, and the old results are computed mod 13.
  - Afterwards, x = 3·m + 7 gives r = 7.
- **Simultaneous request:** assert cfg_valid_i and in_valid_i together on an idle configured block.
  - The load completes and in_ready_o = 0 in that cycle.
  - The operand is accepted in the next cycle under the new modulus.
- **Reset mid-operation:** pulse rst_i with 3 entries in flight.
  - The next cycle shows out_valid_o=0, busy_o=0, cfg_loaded_o=0, in_ready_o=0 and out_r_o=0.
  - No stale result appears afterwards.
